dsram_like_bridge: RTL

Data-side bus bridge sitting directly downstream of the address-translation MMU in the memory stage. Takes the CPU's single-cycle data request (already-translated physical address plus uncached attribute) and converts it into one SRAM-like transaction (req/addr_ok/data_ok). It stalls the pipeline until the transaction completes and holds read data while the pipeline is stalled by other sources, so a request is never issued twice.

---
 rtl/dsram_like_bridge_pkg.sv | 24 ++
 rtl/dsram_like_bridge_if.sv | 49 ++++
 rtl/dsram_like_bridge.sv | 100 ++++++++++
 3 files changed

// File: rtl/dsram_like_bridge_pkg.sv
// Shared definitions for the SRAM-like bus bridges (data side and instruction side).
//
// Contents:
//   bridge_state_e : four-phase transaction FSM (idle, address, data, done)
//   SZ_BYTE/HALF/WORD : encodings of the 2-bit access size field
//   is_write()     : a request is a store when any byte-write lane is enabled
package dsram_like_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } bridge_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic is_write(input logic [3:0] wen);
    return |wen;
  endfunction

endpackage

// File: rtl/dsram_like_bridge_if.sv
// SRAM-like data bus between the bridge (master) and the memory system (slave).
//
// Signals:
//   data_req      master->slave  request valid, held until data_addr_ok
//   data_wr       master->slave  1 = write
//   data_size     master->slave  0 byte, 1 half, 2 word
//   data_addr     master->slave  physical address
//   data_wdata    master->slave  store data, lane-aligned
//   data_uncached master->slave  uncached attribute
//   data_addr_ok  slave->master  address accepted
//   data_data_ok  slave->master  read data valid / write done
//   data_rdata    slave->master  read data
interface dsram_like_bridge_if;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_uncached;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    output data_uncached,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    input  data_uncached,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );

endinterface

// File: rtl/dsram_like_bridge.sv
// Data-side bridge: turns the memory stage's single-cycle request into exactly one
// SRAM-like bus transaction, stalls the pipeline until it completes, and holds the
// load result while the pipeline is frozen by other sources.
//
// Parameters:
//   STALL_ON_WRITE : 1 = writes stall until data_ok, 0 = writes release after addr_ok
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_data_en         memory-stage access valid
//   cpu_data_wen        byte write mask (all-zero = read)
//   cpu_data_size       access size
//   cpu_data_paddr      physical address from the MMU
//   cpu_data_wdata      store data
//   cpu_data_no_cache   uncached attribute from the MMU
//   cpu_longest_stall   pipeline frozen by any source
//   cpu_data_rdata      load result (held buffer)
//   cpu_data_stall      bridge stall request
//   bus                 SRAM-like bus, master side
module dsram_like_bridge
  import dsram_like_bridge_pkg::*;
#(
  parameter bit STALL_ON_WRITE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_data_en,
  input  logic [3:0]                 cpu_data_wen,
  input  logic [1:0]                 cpu_data_size,
  input  logic [31:0]                cpu_data_paddr,
  input  logic [31:0]                cpu_data_wdata,
  input  logic                       cpu_data_no_cache,
  input  logic                       cpu_longest_stall,
  output logic [31:0]                cpu_data_rdata,
  output logic                       cpu_data_stall,
  dsram_like_bridge_if.master        bus
);

  bridge_state_e state;
  logic [31:0]   rdata_buf;

  // Single registered FSM: bus outputs are loaded on IDLE exit and stay stable
  // until the address handshake, so the slave never sees them change mid-request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= StIdle;
      bus.data_req      <= 1'b0;
      bus.data_wr       <= 1'b0;
      bus.data_size     <= 2'd0;
      bus.data_addr     <= 32'd0;
      bus.data_wdata    <= 32'd0;
      bus.data_uncached <= 1'b0;
      rdata_buf         <= 32'd0;
    end else begin
      case (state)
        StIdle: begin
          // A stray data_ok here belongs to no transaction of ours; ignore it.
          if (cpu_data_en) begin
            state             <= StAddr;
            bus.data_req      <= 1'b1;
            bus.data_wr       <= is_write(cpu_data_wen);
            bus.data_size     <= cpu_data_size;
            bus.data_addr     <= cpu_data_paddr;
            bus.data_wdata    <= cpu_data_wdata;
            bus.data_uncached <= cpu_data_no_cache;
          end
        end
        StAddr: begin
          if (bus.data_addr_ok) begin
            bus.data_req <= 1'b0;
            if (bus.data_data_ok) begin
              state <= StDone;
              if (!bus.data_wr) rdata_buf <= bus.data_rdata;
            end else if (!STALL_ON_WRITE && bus.data_wr) begin
              // Posted write: the later data_ok arrives while IDLE/DONE and is dropped.
              state <= StDone;
            end else begin
              state <= StData;
            end
          end
        end
        StData: begin
          if (bus.data_data_ok) begin
            state <= StDone;
            if (!bus.data_wr) rdata_buf <= bus.data_rdata;
          end
        end
        StDone: begin
          // Hold here while the pipeline is frozen so the still-valid cpu_data_en
          // is not mistaken for a new request.
          if (!cpu_longest_stall) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign cpu_data_rdata = rdata_buf;
  assign cpu_data_stall = cpu_data_en & (state != StDone);

endmodule
